bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment scan FSM. It converts a 14-bit unsigned binary value into four packed BCD digits using iterative shift-and-add-3 (double dabble), one bit per clock. The result is held stable on `bcd` between conversions, so the scan stage can multiplex it without tearing.

## Interface
- No parameters. Widths are fixed: 14-bit input and 4 BCD digits.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-low (0 = reset). Sampled only on the rising edge of `clk`.
- `start` input 1: request a conversion. Sampled only in IDLE.
- `bin` input 14: unsigned binary value. Captured on the accepting edge.
- `bcd` output 16: packed BCD, `[15:12]` thousands to `[3:0]` units. Feeds the scan stage `data` input.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when `bcd` has just been updated.
- `overflow` output 1: set if the last captured `bin` exceeded 9999. Updated together with `bcd`.

## Operation
- **States.** IDLE and SHIFT. Held in a registered state variable plus a 4-bit iteration counter.
- **IDLE → SHIFT** on `start`=1:
  - Load the 34-bit work register with {20'b0, bin_eff}.
  - Clear the counter.
  - Latch `ovf_pending` = (`bin` > 9999).
- **SHIFT.** Each cycle, every 4-bit BCD nibble of the upper 20 bits that is ≥5 gets +3 (combinational). Then the whole register shifts left by 1 and the counter increments.
- **SHIFT → IDLE** on the edge that performs iteration 14 (counter = 13). On that same edge:
  - `bcd` ← lower 16 BCD bits of the post-shift result; the ten-thousands nibble is discarded.
  - `overflow` ← `ovf_pending`.
  - `done` ← 1.
- **Outside completion.** `bcd` and `overflow` change only at completion or reset. They hold their values indefinitely in IDLE.
- **`start` while busy.** Ignored, including on the completion edge. A new request is accepted at the earliest on the edge after `done` rises.
- **`bin` changes during SHIFT.** No effect.
- **Arithmetic.** Input range is 0..16383. Without saturation, values above 9999 yield `bin` mod 10000.

## Timing
- **Reset** (`reset`=0 at an edge): state=IDLE, counter=0, `bcd`=16'h0000, `busy`=0, `done`=0, `overflow`=0.
  - Reset overrides `start` and aborts any conversion in progress. `bcd` returns to 0, not the previous result.
- **Cycle-level sequence.** `start` sampled high at edge N:
  - `busy`=1 from after edge N through edge N+14.
  - Iterations occur at edges N+1..N+14.
  - `bcd`, `overflow` and `done`=1 are visible after edge N+14. `busy` is 0 at the same time.
  - `done` returns to 0 after edge N+15.
- **Latency.** 14 cycles from the accepting edge to a valid `bcd`.
- **Throughput.** One conversion per 15 cycles with `start` held high.
- **Registration.** `done` and `busy` are registered, glitch-free, and never high together.

## Configuration
- **`BIN2BCD_SATURATE_EN` defined:** if `bin` > 9999, `bin_eff` = 9999. Result is `bcd`=16'h9999 and `overflow`=1.
- **`BIN2BCD_SATURATE_EN` undefined:** `bin_eff` = `bin`. The result is the low four digits of the true value (16'h(bin mod 10000)), with `overflow`=1 whenever `bin` > 9999.
- In both builds, latency and handshake are identical.

## Test plan
- **Reset.** Hold `reset`=0 for 2 cycles, then release → `bcd`=0000, `busy`=0, `done`=0, `overflow`=0. Keep `start`=0 for 20 cycles → all outputs unchanged.
- **Directed conversions.**
  - `bin`=0 → `bcd`=16'h0000, `overflow`=0.
  - `bin`=1234 → 16'h1234.
  - `bin`=9999 → 16'h9999.
  - In each case `done` pulses exactly 14 cycles after the accepting edge and lasts 1 cycle.
- **Overflow.** `bin`=12345 → `overflow`=1, with `bcd`=16'h9999 (macro defined) or 16'h2345 (macro undefined).
- **Busy protection.**
  - Start with 4321, then at cycle 5 pulse `start` with `bin`=1111 → result is 16'h4321 and only one `done`.
  - Holding `start` high gives back-to-back results spaced 15 cycles apart.
- **Reset mid-conversion.** Start with 5678, pull `reset`=0 at cycle 7 for 1 cycle → `bcd`=0000, `done` never pulses. A subsequent start with 42 → 16'h0042 after 14 cycles.
- **Input stability.** Change `bin` every cycle during SHIFT → result equals the value captured on the accepting edge.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double dabble, one bit per clock).
// Optional BIN2BCD_SATURATE_EN clamps inputs above 9999 to 9999; otherwise the result is bin mod 10000.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [33:0] work, work_nxt, work_adj, work_shl;
  logic        ovf_pending, ovf_pending_nxt;
  logic [15:0] bcd_nxt;
  logic        busy_nxt, done_nxt, overflow_nxt;
  logic [13:0] bin_eff;
  logic        bin_big;

  assign bin_big = (bin > 14'd9999);

`ifdef BIN2BCD_SATURATE_EN
  assign bin_eff = bin_big ? 14'd9999 : bin;
`else
  assign bin_eff = bin;
`endif

  // Add-3 correction on every BCD nibble of the upper 20 bits before the shift.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < 5; i++) begin
      if (work[14 + 4*i +: 4] >= 4'd5)
        work_adj[14 + 4*i +: 4] = work[14 + 4*i +: 4] + 4'd3;
    end
    work_shl = work_adj << 1;
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    work_nxt        = work;
    ovf_pending_nxt = ovf_pending;
    bcd_nxt         = bcd;
    overflow_nxt    = overflow;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          state_nxt       = SHIFT;
          work_nxt        = {20'b0, bin_eff};
          cnt_nxt         = 4'd0;
          ovf_pending_nxt = bin_big;
          busy_nxt        = 1'b1;
        end
      end
      SHIFT: begin
        work_nxt = work_shl;
        cnt_nxt  = cnt + 4'd1;
        if (cnt == 4'd13) begin
          // Ten-thousands nibble [33:30] is dropped; only four digits leave the block.
          state_nxt    = IDLE;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
          bcd_nxt      = work_shl[29:14];
          overflow_nxt = ovf_pending;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      work        <= 34'd0;
      ovf_pending <= 1'b0;
      bcd         <= 16'h0000;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      work        <= work_nxt;
      ovf_pending <= ovf_pending_nxt;
      bcd         <= bcd_nxt;
      overflow    <= overflow_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, handshake, overflow, busy protection and mid-run reset.
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start a conversion at the next edge and follow it to completion.
  task automatic convert(input string tag, input logic [13:0] val, input logic [15:0] exp_bcd,
                         input logic exp_ovf, input bit scramble);
    int k;
    int both;
    k = 0;
    both = 0;
    @(negedge clk);
    bin   = val;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_accept"}, busy, 1);
    chk({tag, "_done_after_accept"}, done, 0);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      k = i;
      if (busy && done) both++;
      if (scramble) bin = 14'($urandom_range(0, 16383));
      if (done) break;
    end
    chk({tag, "_latency"}, k, 14);
    chk({tag, "_bcd"}, bcd, exp_bcd);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_busy_done_overlap"}, both, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_bcd_hold"}, bcd, exp_bcd);
  endtask

  initial begin
    int n_done;
    int first_done;
    int second_done;
    logic [15:0] ovf_exp;

    reset = 1'b0;
    start = 1'b0;
    bin   = 14'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_bcd", bcd, 16'h0000);
    chk("rel_busy", busy, 0);
    chk("rel_done", done, 0);
    chk("rel_ovf", overflow, 0);
    bin = 14'd1234;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("idle_bcd", bcd, 16'h0000);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    convert("zero", 14'd0, 16'h0000, 1'b0, 1'b0);
    convert("c1234", 14'd1234, 16'h1234, 1'b0, 1'b0);
    convert("c9999", 14'd9999, 16'h9999, 1'b0, 1'b0);
`ifdef BIN2BCD_SATURATE_EN
    ovf_exp = 16'h9999;
`else
    ovf_exp = 16'h2345;
`endif
    convert("c12345", 14'd12345, ovf_exp, 1'b1, 1'b0);
    convert("c16383", 14'd16383, ovf_exp == 16'h9999 ? 16'h9999 : 16'h6383, 1'b1, 1'b0);
    convert("c0009", 14'd9, 16'h0009, 1'b0, 1'b0);

    // Busy protection: second start at cycle 5 must be ignored.
    @(negedge clk);
    bin   = 14'd4321;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    first_done = -1;
    for (int i = 1; i <= 35; i++) begin
      if (i == 5) begin
        bin   = 14'd1111;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = i;
      end
    end
    start = 1'b0;
    chk("busyprot_dones", n_done, 1);
    chk("busyprot_cycle", first_done, 14);
    chk("busyprot_bcd", bcd, 16'h4321);

    // Back-to-back with start held high.
    @(negedge clk);
    bin   = 14'd77;
    start = 1'b1;
    first_done = -1;
    second_done = -1;
    for (int i = 0; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
    end
    start = 1'b0;
    chk("b2b_first", first_done, 14);
    chk("b2b_spacing", second_done - first_done, 15);
    chk("b2b_bcd", bcd, 16'h0077);
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(posedge clk);
      @(negedge clk);
    end
    chk("b2b_drain", busy, 0);
    repeat (2) @(posedge clk);

    // Reset mid-conversion.
    @(negedge clk);
    bin   = 14'd5678;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_bcd", bcd, 16'h0000);
    chk("midrst_busy", busy, 0);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst_nodone", n_done, 0);
    chk("midrst_bcd_hold", bcd, 16'h0000);
    convert("c42", 14'd42, 16'h0042, 1'b0, 1'b0);

    // Input changes during SHIFT have no effect.
    convert("stable", 14'd8765, 16'h8765, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
